// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - frame scan controller: raster pixel reads packed into two-pixel panel beats
module display_scan_ctrl #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int HBLANK = 4,
  parameter int ADDR_W = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              START,
  input  logic              DISP_READY,
  output logic              MEM_RD,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [23:0]       MEM_RDATA,
  output logic              RECON_VALID,
  output logic [7:0]        DATA_RECON_R0,
  output logic [7:0]        DATA_RECON_G0,
  output logic [7:0]        DATA_RECON_B0,
  output logic [7:0]        DATA_RECON_R1,
  output logic [7:0]        DATA_RECON_G1,
  output logic [7:0]        DATA_RECON_B1,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int XW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH / 2 - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  // blank counter holds the remaining cycles minus one, so it lasts HBLANK cycles
  localparam logic [BW-1:0] B_LOAD = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, OUT, BLANK, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [BW-1:0]       bcnt;
  logic [23:0]         pix0;
  logic [23:0]         pix1;

  // beat data always comes straight from the capture registers, so it cannot move while OUT waits
  assign DATA_RECON_R0 = pix0[23:16];
  assign DATA_RECON_G0 = pix0[15:8];
  assign DATA_RECON_B0 = pix0[7:0];
  assign DATA_RECON_R1 = pix1[23:16];
  assign DATA_RECON_G1 = pix1[15:8];
  assign DATA_RECON_B1 = pix1[7:0];

  // state register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state and output decode, all outputs derived from the registered state
  always_comb begin
    state_nxt   = state;
    MEM_RD      = 1'b0;
    MEM_ADDR    = '0;
    RECON_VALID = 1'b0;
    FRAME_DONE  = 1'b0;
    BUSY        = (state != IDLE);
    case (state)
      IDLE: if (START) state_nxt = RD0;
      RD0: begin
        MEM_RD    = 1'b1;
        MEM_ADDR  = ptr;
        state_nxt = RD1;
      end
      RD1: begin
        MEM_RD    = 1'b1;
        MEM_ADDR  = ptr + ADDR_W'(1);
        state_nxt = CAP;
      end
      CAP: state_nxt = OUT;
      OUT: begin
        RECON_VALID = 1'b1;
        if (DISP_READY) begin
          if (x != X_LAST)      state_nxt = RD0;
          else if (y != Y_LAST) state_nxt = (HBLANK > 0) ? BLANK : RD0;
          else                  state_nxt = DONE;
        end
      end
      BLANK: if (bcnt == '0) state_nxt = RD0;
      DONE: begin
        FRAME_DONE = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // address/position counters, blank timer and pixel capture
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ptr  <= '0;
      x    <= '0;
      y    <= '0;
      bcnt <= '0;
      pix0 <= '0;
      pix1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            ptr <= '0;
            x   <= '0;
            y   <= '0;
          end
        end
        RD1: pix0 <= MEM_RDATA;
        CAP: pix1 <= MEM_RDATA;
        OUT: begin
          if (DISP_READY) begin
            ptr <= ptr + ADDR_W'(2);
            if (x != X_LAST) begin
              x <= x + XW'(1);
            end else if (y != Y_LAST) begin
              x    <= '0;
              y    <= y + YW'(1);
              bcnt <= B_LOAD;
            end
          end
        end
        BLANK: if (bcnt != '0) bcnt <= bcnt - BW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl on a 4x2 frame
module tb_display_scan_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int AW = 4;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          ready;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_rdata;
  logic          valid;
  logic [7:0]    r0, g0, b0, r1, g1, b1;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int beats  = 0;
  int b0_snap;

  display_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .ADDR_W(AW)) dut (
    .HCLK(clk), .HRESETn(rstn), .START(start), .DISP_READY(ready),
    .MEM_RD(mem_rd), .MEM_ADDR(mem_addr), .MEM_RDATA(mem_rdata),
    .RECON_VALID(valid),
    .DATA_RECON_R0(r0), .DATA_RECON_G0(g0), .DATA_RECON_B0(b0),
    .DATA_RECON_R1(r1), .DATA_RECON_G1(g1), .DATA_RECON_B1(b1),
    .BUSY(busy), .FRAME_DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int i);
    logic [7:0] v;
    v = 8'(i);
    return {v, v + 8'h40, v + 8'h80};
  endfunction

  // memory model: registered read, data valid the cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= pix(int'(mem_addr));
  end

  // accepted-beat counter, sampled mid-cycle
  always @(negedge clk) begin
    if (rstn && valid && ready) beats <= beats + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // state is RD0 on entry; leaves the DUT in OUT presenting beat k
  task automatic fetch(input int k);
    chk($sformatf("rd0_strobe_b%0d", k), 48'(mem_rd), 48'd1);
    chk($sformatf("rd0_addr_b%0d", k), 48'(mem_addr), 48'(2 * k));
    chk($sformatf("rd0_valid_b%0d", k), 48'(valid), 48'd0);
    step();
    chk($sformatf("rd1_addr_b%0d", k), {47'd0, mem_rd, 44'd0} | 48'(mem_addr), {47'd0, 1'b1, 44'd0} | 48'(2 * k + 1));
    step();
    chk($sformatf("cap_idle_b%0d", k), 48'({mem_rd, mem_addr, valid}), 48'd0);
    step();
    chk($sformatf("out_valid_b%0d", k), 48'(valid), 48'd1);
    chk($sformatf("out_data_b%0d", k), {r0, g0, b0, r1, g1, b1}, {pix(2 * k), pix(2 * k + 1)});
  endtask

  task automatic chk_blank(input string tag);
    chk(tag, 48'({valid, mem_rd, mem_addr, busy}), 48'd1);
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    #1;
    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      ready = 1'($urandom);
      step();
    end
    chk("rst_outputs", 48'({mem_rd, mem_addr, valid, busy, done}), 48'd0);
    chk("rst_data", {r0, g0, b0, r1, g1, b1}, 48'd0);
    rstn  = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    step();
    step();
    chk("idle_hold_busy", 48'(busy), 48'd0);
    chk("idle_hold_rd", 48'(mem_rd), 48'd0);

    // frame 1: nominal, ready held high
    b0_snap = beats;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("f1_busy", 48'(busy), 48'd1);
    fetch(0);
    step();
    fetch(1);
    step();
    chk_blank("f1_blank0");
    step();
    chk_blank("f1_blank1");
    step();
    fetch(2);
    step();
    fetch(3);
    step();
    chk("f1_done", 48'({done, busy, valid}), 48'b110);
    step();
    chk("f1_idle", 48'({done, busy}), 48'd0);
    chk("f1_beats", 48'(beats - b0_snap), 48'd4);

    // frame 2: backpressure on beat 1, START pulses mid-frame and on FRAME_DONE
    b0_snap = beats;
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(0);
    step();
    fetch(1);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_valid_%0d", i), 48'({valid, mem_rd}), 48'b10);
      chk($sformatf("bp_data_%0d", i), {r0, g0, b0, r1, g1, b1}, {pix(2), pix(3)});
    end
    ready = 1'b1;
    step();
    chk_blank("f2_blank0");
    start = 1'b1;
    step();
    start = 1'b0;
    chk_blank("f2_blank1");
    step();
    fetch(2);
    step();
    fetch(3);
    step();
    chk("f2_done", 48'(done), 48'd1);
    start = 1'b1;
    step();
    chk("f2_done_start_ignored", 48'({busy, mem_rd, done}), 48'd0);
    chk("f2_beats", 48'(beats - b0_snap), 48'd4);
    step();
    start = 1'b0;

    // frame 3 begins at address 0 from the IDLE-cycle START, then reset in beat 2
    fetch(0);
    step();
    fetch(1);
    step();
    chk_blank("f3_blank0");
    step();
    step();
    fetch(2);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("midrst_outputs", 48'({mem_rd, mem_addr, valid, busy, done}), 48'd0);
    chk("midrst_data", {r0, g0, b0, r1, g1, b1}, 48'd0);
    step();
    chk("midrst_stays_idle", 48'(busy), 48'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(0);
    step();
    fetch(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Frame scan controller that feeds the display panel. On a start pulse it reads one frame of 24-bit pixels from a single-port pixel memory in raster order. It packs each pair of horizontally adjacent pixels into one two-pixel beat and drives the panel's RECON_VALID / DATA_RECON_* stream, with ready backpressure and optional per-line blanking. It sits between the frame buffer and the panel model and signals frame completion.

## Interface
- WIDTH, 768, pixels per line; even, ≥2
- HEIGHT, 512, lines per frame; ≥1
- HBLANK, 4, idle cycles inserted after each line except the last; 0 allowed
- ADDR_W, 19, memory address width; 2^ADDR_W ≥ WIDTH*HEIGHT

Ports:
- HCLK  in  1  clock, all logic on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- START  in  1  frame request, sampled only in IDLE
- DISP_READY  in  1  panel accepts the current beat; tie high for a panel without backpressure
- MEM_RD  out  1  memory read strobe
- MEM_ADDR  out  ADDR_W  pixel address, raster order, pixel (x,y) = y*WIDTH+x
- MEM_RDATA  in  24  {R[23:16],G[15:8],B[7:0]}, valid the cycle after MEM_RD
- RECON_VALID  out  1  beat valid
- DATA_RECON_R0/G0/B0  out  8 each  left pixel (even x)
- DATA_RECON_R1/G1/B1  out  8 each  right pixel (odd x)
- BUSY  out  1  high in every state except IDLE
- FRAME_DONE  out  1  one-cycle pulse after the last beat is accepted

## Operation
- State machine: IDLE, RD0, RD1, CAP, OUT, BLANK, DONE.
- IDLE: START=1 → RD0; clears ptr=0, x=0 (beat index within line), y=0.
- RD0: MEM_RD=1, MEM_ADDR=ptr → RD1.
- RD1: MEM_RD=1, MEM_ADDR=ptr+1; pix0 ← MEM_RDATA → CAP.
- CAP: pix1 ← MEM_RDATA → OUT.
- OUT: RECON_VALID=1; DATA_RECON_* come from the pix0/pix1 registers and are stable while in OUT.
  - DISP_READY=0: stay in OUT; ptr, x, y and data unchanged.
  - DISP_READY=1 (beat accepted): ptr ← ptr+2.
    - x<WIDTH/2-1: x ← x+1 → RD0.
    - x==WIDTH/2-1 and y<HEIGHT-1: x ← 0, y ← y+1 → BLANK if HBLANK>0, else RD0.
    - x==WIDTH/2-1 and y==HEIGHT-1: → DONE.
- BLANK: the counter loads HBLANK-1 on entry and decrements each cycle; at 0 → RD0. RECON_VALID=0, MEM_RD=0.
- DONE: FRAME_DONE=1 for exactly one cycle → IDLE.
- In any state other than IDLE, START is ignored; no queuing.
- MEM_RD/MEM_ADDR decode from the state register. MEM_ADDR=0 whenever MEM_RD=0.
- Beats per frame = WIDTH/2*HEIGHT (196608 at the defaults). ptr never exceeds WIDTH*HEIGHT.

## Timing
- Reset (HRESETn=0 at an edge, any state): the next cycle shows IDLE, with MEM_RD=0, MEM_ADDR=0, RECON_VALID=0, all DATA_RECON_*=0, BUSY=0, FRAME_DONE=0. ptr, x, y, the blank counter and pix0/pix1 are cleared. An in-progress frame is abandoned, and a new START is required.
- START sampled at edge T: RD0 is visible at T+1, the first RECON_VALID at T+4.
- With DISP_READY held high, each beat takes 4 cycles, so RECON_VALID is a 1-in-4 pulse train.
- Each line costs 4*WIDTH/2 + HBLANK cycles. The last line has no blank.
- FRAME_DONE appears the cycle after the final accepted beat. BUSY falls the cycle after FRAME_DONE.
- An accepted beat is one where RECON_VALID and DISP_READY are both high at the same edge. Data must not change between the first valid cycle and acceptance.

## Test plan
- Reset: drive random inputs with HRESETn=0 for 3 cycles → every output is 0 and BUSY=0. Release with START=0 → the block stays IDLE.
- Small frame, WIDTH=4, HEIGHT=2, HBLANK=2, memory word i = {i, i+8'h40, i+8'h80}, DISP_READY=1. Required response:
  - exactly 4 beats; beat k carries R0=2k, R1=2k+1;
  - first valid 4 cycles after START; a 2-cycle gap after beat 1;
  - FRAME_DONE pulse one cycle after beat 3.
- Backpressure: hold DISP_READY=0 for 5 cycles during beat 1 → RECON_VALID and data hold for 6 cycles, MEM_RD stays 0, and the following beat carries pixels 4/5.
- START handling: pulse START mid-frame and again on the FRAME_DONE cycle → both are ignored and beat count is unchanged. START in the following IDLE cycle begins a new frame at address 0.
- Reset mid-frame: assert HRESETn=0 in OUT of beat 2 → IDLE with outputs 0 next cycle. A fresh START restarts from pixel 0.
- Defaults with the display panel model, DISP_READY=1 → 196608 beats. The panel's DEC_DONE rises and the written image matches the memory contents pixel for pixel.
